segment_reader: RTL and testbench
=================================

SEGMENT_READER -- requirements
Module: segment_reader

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of multiplexed digits captured per frame (range 1..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive identical samples required before a digit is captured (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port seg, input, 7 bits: active-low segment lines, bit0=a .. bit6=g.
REQ-006 SHALL have port dig_sel, input, DIGITS bits: one-hot select of the digit currently driven on seg; bit i = digit i.
REQ-007 SHALL have port value, output, 4*DIGITS bits: decoded frame; nibble i = digit i.
REQ-008 SHALL have port bad_mask, output, DIGITS bits: bit i set when digit i held a non-hex pattern in the frame.
REQ-009 SHALL have port out_valid, output, 1 bit: frame available on value/bad_mask.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the frame.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag for a frame lost while out_valid was pending.

Function
REQ-012 SHALL decode seg (hex, 7-bit) as 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-013 SHALL treat every other pattern, including 3F (dash) and 7F (blank), as invalid: nibble 0, bad bit set.
REQ-014 SHALL register seg and dig_sel once before use; all counting uses registered copies (one cycle of input latency).
REQ-015 SHALL run a capture FSM with states WAIT, SETTLE, HELD.
REQ-016 WAIT: when registered dig_sel is one-hot, load the stability counter with 1, record seg and dig_sel, and go to SETTLE; otherwise stay.
REQ-017 SETTLE: if seg or dig_sel differs from the recorded values, reload the counter with 1 and record the new values (go to WAIT if dig_sel is not one-hot); else increment the counter.
REQ-018 SETTLE: when the counter reaches STABLE_CYCLES, write the decoded nibble and bad bit into digit slot i (i = index of dig_sel), set captured bit i, and go to HELD in the same cycle.
REQ-019 HELD: stay until seg or dig_sel changes, then act as WAIT on the new values in that cycle; a digit SHALL be captured at most once per dwell.
REQ-020 Recapture of an already-captured digit in the same frame SHALL overwrite its slot.
REQ-021 When all DIGITS captured bits are set, the frame SHALL complete: clear all captured bits on the next edge and, if out_valid is 0, load value/bad_mask and set out_valid on that edge.
REQ-022 Frame completion while out_valid=1 and out_ready=0 SHALL discard the new frame, keep value/bad_mask unchanged, and set overflow.
REQ-023 Frame completion in the same cycle as an out_valid and out_ready handshake SHALL load the new frame, keeping out_valid at 1 (no bubble, no overflow).
REQ-024 A handshake (out_valid and out_ready) SHALL clear out_valid on the next edge when no frame completes in that cycle.
REQ-025 value and bad_mask SHALL be stable while out_valid=1.
REQ-026 overflow SHALL stay set until rst.
REQ-027 With STABLE_CYCLES=1, capture SHALL occur in the cycle the FSM leaves WAIT.

Reset
REQ-028 rst=1 SHALL force FSM=WAIT, counter=0, captured bits=0, value=0, bad_mask=0, out_valid=0, overflow=0, and clear input registers to seg=7F and dig_sel=0.
REQ-029 rst asserted mid-dwell or mid-frame SHALL discard all partial captures; the first frame after reset needs every digit captured anew.

Verification
REQ-030 DIGITS=4, STABLE_CYCLES=4; drive digits 0..3 with 30,12,08,46, 6 cycles each, out_ready=0 -> out_valid=1, value=0xCA53, bad_mask=0.
REQ-031 Digit 1 shows 79 for 3 cycles, then 24 for 6 cycles -> slot 1 = 2, never 1.
REQ-032 Digit 2 shows 3F -> frame has nibble 2 = 0 and bad_mask=0100b.
REQ-033 Complete two frames with out_ready=0 -> overflow=1 and value holds the first frame; then out_ready=1 for one cycle -> out_valid=0.
REQ-034 Hold out_ready=1 so the handshake coincides with the next frame's completion -> out_valid stays 1, value updates, and overflow stays 0.
REQ-035 Assert rst after capturing digits 0..2, then complete digit 3 -> no out_valid until all four digits are recaptured.

Source files
------------

// File: rtl/segment_reader.sv
// Captures a multiplexed 7-segment display (active-low segments, one-hot digit select) into hex frames.
// Each digit must hold steady for STABLE_CYCLES samples before it is decoded into its frame slot.
module segment_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     bad_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow
);

  typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   dig_q;
  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [6:0]          rec_seg_q, rec_seg_d;
  logic [DIGITS-1:0]   rec_dig_q, rec_dig_d;
  logic [4*DIGITS-1:0] slot_val_q;
  logic [DIGITS-1:0]   slot_bad_q, captured_q;
  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   bad_q;
  logic                valid_q, overflow_q;

  logic                one_hot, changed, start, capture, complete;
  logic [DIGITS-1:0]   cap_mask;
  logic [4:0]          dec;

  // Returns {bad, nibble}; unknown patterns (dash, blank, anything else) decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h00;
      7'h79: decode = 5'h01;
      7'h24: decode = 5'h02;
      7'h30: decode = 5'h03;
      7'h19: decode = 5'h04;
      7'h12: decode = 5'h05;
      7'h02: decode = 5'h06;
      7'h78: decode = 5'h07;
      7'h00: decode = 5'h08;
      7'h10: decode = 5'h09;
      7'h08: decode = 5'h0A;
      7'h03: decode = 5'h0B;
      7'h46: decode = 5'h0C;
      7'h21: decode = 5'h0D;
      7'h06: decode = 5'h0E;
      7'h0E: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    one_hot   = (dig_q != '0) && ((dig_q & (dig_q - DIGITS'(1))) == '0);
    changed   = (seg_q != rec_seg_q) || (dig_q != rec_dig_q);
    start     = one_hot && ((state_q == WAIT) || changed);
    state_d   = state_q;
    cnt_d     = cnt_q;
    rec_seg_d = rec_seg_q;
    rec_dig_d = rec_dig_q;
    capture   = 1'b0;
    case (state_q)
      WAIT: ;
      SETTLE: begin
        if (changed) begin
          cnt_d     = 8'd1;
          rec_seg_d = seg_q;
          rec_dig_d = dig_q;
          if (!one_hot) state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == STABLE) begin
            capture = 1'b1;
            state_d = HELD;
          end
        end
      end
      HELD: if (changed && !one_hot) state_d = WAIT;
      default: state_d = WAIT;
    endcase
    // A new one-hot dwell restarts counting; a one-sample threshold captures immediately.
    if (start) begin
      cnt_d     = 8'd1;
      rec_seg_d = seg_q;
      rec_dig_d = dig_q;
      if (STABLE == 8'd1) begin
        capture = 1'b1;
        state_d = HELD;
      end else begin
        state_d = SETTLE;
      end
    end
    cap_mask = capture ? dig_q : '0;
    dec      = decode(seg_q);
    complete = &captured_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= 7'h7F;
      dig_q      <= '0;
      state_q    <= WAIT;
      cnt_q      <= '0;
      rec_seg_q  <= 7'h7F;
      rec_dig_q  <= '0;
      slot_val_q <= '0;
      slot_bad_q <= '0;
      captured_q <= '0;
      value_q    <= '0;
      bad_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      seg_q     <= seg;
      dig_q     <= dig_sel;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rec_seg_q <= rec_seg_d;
      rec_dig_q <= rec_dig_d;
      for (int i = 0; i < DIGITS; i++) begin
        if (cap_mask[i]) begin
          slot_val_q[4*i +: 4] <= dec[3:0];
          slot_bad_q[i]        <= dec[4];
        end
      end
      // A digit captured in the completion cycle already belongs to the next frame.
      captured_q <= (complete ? '0 : captured_q) | cap_mask;
      if (complete) begin
        if (!valid_q || out_ready) begin
          value_q <= slot_val_q;
          bad_q   <= slot_bad_q;
          valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign value     = value_q;
  assign bad_mask  = bad_q;
  assign out_valid = valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_segment_reader.sv
// Drives two segment_reader instances (threshold 4 and threshold 1) with directed and random
// display traffic and compares them every cycle with a run-length reference model.
module tb_segment_reader;

  localparam int STAB[2] = '{4, 1};
  localparam logic [6:0] PAT[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        out_ready;
  logic [15:0] value0, value1;
  logic [3:0]  bad0, bad1;
  logic        valid0, valid1, ovf0, ovf1;

  int assertions = 0;
  int failures   = 0;

  logic [15:0] mVal[2], mSlotVal[2];
  logic [3:0]  mBad[2], mSlotBad[2], mCap[2], mLastDig[2];
  logic        mValid[2], mOvf[2];
  logic [6:0]  mLastSeg[2];
  int          mRun[2];
  logic [6:0]  pSeg;
  logic [3:0]  pDig;

  always #5 clk = ~clk;

  segment_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel), .value(value0), .bad_mask(bad0),
    .out_valid(valid0), .out_ready(out_ready), .overflow(ovf0));

  segment_reader #(.DIGITS(4), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel), .value(value1), .bad_mask(bad1),
    .out_valid(valid1), .out_ready(out_ready), .overflow(ovf1));

  function automatic logic [4:0] refDecode(input logic [6:0] s);
    logic [4:0] r = 5'h10;
    for (int i = 0; i < 16; i++)
      if (PAT[i] == s) r = {1'b0, 4'(i)};
    return r;
  endfunction

  // One clock edge of the reference: the display sample seen now is the one driven an edge ago.
  task automatic modelStep(input logic [6:0] s, input logic [3:0] d, input logic r, input logic rs);
    logic complete, oneHot;
    logic [3:0] capBit;
    logic [4:0] dv;
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        mVal[k] = '0; mBad[k] = '0; mValid[k] = 1'b0; mOvf[k] = 1'b0;
        mSlotVal[k] = '0; mSlotBad[k] = '0; mCap[k] = '0;
        mRun[k] = 0; mLastSeg[k] = 7'h7F; mLastDig[k] = '0;
      end else begin
        complete = (mCap[k] == 4'hF);
        if (complete) begin
          if (!mValid[k] || r) begin
            mVal[k] = mSlotVal[k]; mBad[k] = mSlotBad[k]; mValid[k] = 1'b1;
          end else mOvf[k] = 1'b1;
        end else if (mValid[k] && r) mValid[k] = 1'b0;
        oneHot = ($countones(pDig) == 1);
        if (!oneHot) mRun[k] = 0;
        else if (pSeg == mLastSeg[k] && pDig == mLastDig[k]) mRun[k]++;
        else mRun[k] = 1;
        mLastSeg[k] = pSeg; mLastDig[k] = pDig;
        capBit = '0;
        if (oneHot && mRun[k] == STAB[k]) begin
          capBit = pDig;
          dv = refDecode(pSeg);
          for (int i = 0; i < 4; i++)
            if (pDig[i]) begin
              mSlotVal[k][4*i +: 4] = dv[3:0];
              mSlotBad[k][i] = dv[4];
            end
        end
        mCap[k] = (complete ? 4'h0 : mCap[k]) | capBit;
      end
    end
    pSeg = rs ? 7'h7F : s;
    pDig = rs ? 4'h0 : d;
  endtask

  task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkEq("value0", value0, mVal[0]);
    checkEq("bad0", 16'(bad0), 16'(mBad[0]));
    checkEq("valid0", 16'(valid0), 16'(mValid[0]));
    checkEq("ovf0", 16'(ovf0), 16'(mOvf[0]));
    checkEq("value1", value1, mVal[1]);
    checkEq("bad1", 16'(bad1), 16'(mBad[1]));
    checkEq("valid1", 16'(valid1), 16'(mValid[1]));
    checkEq("ovf1", 16'(ovf1), 16'(mOvf[1]));
  endtask

  task automatic applyStimulus(input logic [6:0] s, input logic [3:0] d, input logic r);
    seg = s; dig_sel = d; out_ready = r;
    @(posedge clk);
    modelStep(s, d, r, rst);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(7'h7F, 4'h0, 1'b0);
    applyStimulus(7'h7F, 4'h0, 1'b0);
    rst = 1'b0;
  endtask

  // mode 0/1 drives out_ready constant; mode 2 raises it only when the frame is about to complete.
  task automatic showDigit(input int i, input logic [6:0] p, input int n, input int mode);
    for (int c = 0; c < n; c++)
      applyStimulus(p, 4'(1 << i), (mode == 2) ? (mCap[0] == 4'hF) : (mode == 1));
  endtask

  task automatic idle(input int n, input logic r);
    for (int c = 0; c < n; c++) applyStimulus(7'h7F, 4'h0, r);
  endtask

  task automatic showFrame(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                           input logic [6:0] d, input int mode);
    showDigit(0, a, 6, mode);
    showDigit(1, b, 6, mode);
    showDigit(2, c, 6, mode);
    showDigit(3, d, 6, mode);
  endtask

  initial begin
    rst = 1'b1; seg = 7'h7F; dig_sel = '0; out_ready = 1'b0;
    pSeg = 7'h7F; pDig = '0;
    doReset();
    checkEq("reset_value", value0, 16'h0000);
    checkEq("reset_valid", 16'(valid0), 16'h0);
    checkEq("reset_ovf", 16'(ovf0), 16'h0);

    showFrame(7'h30, 7'h12, 7'h08, 7'h46, 0);
    idle(2, 1'b0);
    checkEq("basic_value", value0, 16'hCA53);
    checkEq("basic_bad", 16'(bad0), 16'h0);
    checkEq("basic_valid", 16'(valid0), 16'h1);

    showFrame(7'h79, 7'h24, 7'h30, 7'h19, 0);
    idle(2, 1'b0);
    checkEq("ovf_set", 16'(ovf0), 16'h1);
    checkEq("ovf_hold_value", value0, 16'hCA53);
    idle(1, 1'b1);
    checkEq("handshake_clear", 16'(valid0), 16'h0);

    showDigit(0, 7'h40, 6, 0);
    showDigit(1, 7'h79, 3, 0);
    showDigit(1, 7'h24, 6, 0);
    showDigit(2, 7'h40, 6, 0);
    showDigit(3, 7'h40, 6, 0);
    idle(2, 1'b0);
    checkEq("short_dwell_value", value0, 16'h0020);
    idle(1, 1'b1);

    showFrame(7'h79, 7'h79, 7'h3F, 7'h79, 0);
    idle(2, 1'b0);
    checkEq("dash_value", value0, 16'h1011);
    checkEq("dash_bad", 16'(bad0), 16'h4);
    idle(1, 1'b1);

    doReset();
    showFrame(7'h30, 7'h12, 7'h08, 7'h46, 0);
    showFrame(7'h79, 7'h24, 7'h30, 7'h19, 2);
    idle(2, 1'b0);
    checkEq("nobubble_valid", 16'(valid0), 16'h1);
    checkEq("nobubble_value", value0, 16'h4321);
    checkEq("nobubble_ovf", 16'(ovf0), 16'h0);

    doReset();
    showDigit(0, 7'h79, 6, 0);
    showDigit(1, 7'h24, 6, 0);
    showDigit(2, 7'h30, 6, 0);
    doReset();
    showDigit(3, 7'h19, 6, 0);
    idle(2, 1'b0);
    checkEq("reset_discard", 16'(valid0), 16'h0);
    showFrame(7'h79, 7'h24, 7'h30, 7'h19, 0);
    idle(2, 1'b0);
    checkEq("recapture_value", value0, 16'h4321);

    doReset();
    for (int n = 0; n < 120; n++) begin
      int sel, len;
      logic [3:0] d;
      logic [6:0] p;
      sel = $urandom_range(0, 9);
      d = (sel < 8) ? 4'(1 << (sel % 4)) : ((sel == 8) ? 4'h0 : 4'h3);
      p = ($urandom_range(0, 4) == 0) ? 7'($urandom) : PAT[$urandom_range(0, 15)];
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++)
        applyStimulus(p, d, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
